lfsr_burst_ctrl: RTL and testbench

Sequencer for the serial LFSR generator block (clk, rst, single-bit reg_out). It accepts burst commands (seed, word count) over a valid/ready handshake, seeds the LFSR, and gates its shifting. It packs the serial output into WORD_W-bit words and delivers them on a backpressured valid/ready stream. The LFSR is stalled while a word waits, so no bits are lost.

---
 rtl/lfsr_burst_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lfsr_burst_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer for a serial LFSR: seeds it per command, gates its shifting,
// and packs its output bits MSB-first into words on a backpressured stream.
module lfsr_burst_ctrl #(
    parameter int LFSR_W = 8,
    parameter int WORD_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LFSR_W-1:0] cmd_seed,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              lfsr_load,
    output logic [LFSR_W-1:0] lfsr_seed,
    output logic              lfsr_en,
    input  logic              lfsr_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              err_zero_seed
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

    // IDLE: wait for command | LOAD: seed strobe | SHIFT: sample WORD_W bits | OUT: hold word
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   seed_q, seed_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    word_cnt_q, word_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic                lfsr_load_q, lfsr_load_d;
    logic                lfsr_en_q, lfsr_en_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                err_q, err_d;

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        lfsr_load_d = 1'b0;
        lfsr_en_d   = lfsr_en_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        cmd_ready_d = cmd_ready_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_seed == '0) begin
                        err_d = 1'b1;
                    end else if (cmd_len != '0) begin
                        seed_d      = cmd_seed;
                        len_d       = cmd_len;
                        word_cnt_d  = '0;
                        lfsr_load_d = 1'b1;
                        busy_d      = 1'b1;
                        cmd_ready_d = 1'b0;
                        state_d     = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                lfsr_en_d = 1'b1;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                shift_d   = {shift_q[WORD_W-2:0], lfsr_bit};
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == BIT_LAST) begin
                    // Stop the LFSR while the word waits so no bits are lost.
                    bit_cnt_d   = '0;
                    lfsr_en_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_data_d  = shift_d;
                    out_last_d  = (word_cnt_q == len_q - LEN_W'(1));
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        busy_d      = 1'b0;
                        cmd_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + LEN_W'(1);
                        bit_cnt_d  = '0;
                        lfsr_en_d  = 1'b1;
                        state_d    = S_SHIFT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            seed_q      <= '0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            lfsr_load_q <= 1'b0;
            lfsr_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            lfsr_load_q <= lfsr_load_d;
            lfsr_en_q   <= lfsr_en_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign lfsr_load     = lfsr_load_q;
    assign lfsr_seed     = seed_q;
    assign lfsr_en       = lfsr_en_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_last      = out_last_q;
    assign busy          = busy_q;
    assign err_zero_seed = err_q;

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Bench for lfsr_burst_ctrl: drives an LFSR (x^8+x^6+x^5+x^4+1) from the DUT's
// load/enable strobes and compares every cycle against a cycle-number timeline model.
module tb_lfsr_burst_ctrl;
    localparam int LFSR_W = 8;
    localparam int WORD_W = 8;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LFSR_W-1:0] cmd_seed;
    logic [LEN_W-1:0]  cmd_len;
    logic              lfsr_load;
    logic [LFSR_W-1:0] lfsr_seed;
    logic              lfsr_en;
    logic              lfsr_bit;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              err_zero_seed;

    always #5 clk = ~clk;

    lfsr_burst_ctrl #(.LFSR_W(LFSR_W), .WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_seed(cmd_seed), .cmd_len(cmd_len),
        .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_en(lfsr_en), .lfsr_bit(lfsr_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_zero_seed(err_zero_seed)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // k-th word of a burst: either the LFSR bitstream or the 1,0,1,0 pattern, MSB first
    function automatic logic [WORD_W-1:0] ref_word(input logic [7:0] seed, input int k, input bit pattern);
        logic [7:0] s;
        logic [WORD_W-1:0] w;
        s = seed;
        w = '0;
        if (pattern) begin
            for (int i = 0; i < WORD_W; i++) w = {w[WORD_W-2:0], (((k * WORD_W + i) % 2) == 0)};
        end else begin
            for (int i = 0; i < k * WORD_W; i++) s = lfsr_step(s);
            for (int i = 0; i < WORD_W; i++) begin
                w = {w[WORD_W-2:0], s[7]};
                s = lfsr_step(s);
            end
        end
        return w;
    endfunction

    // Environment: the LFSR itself (or a toggling pattern source)
    logic [7:0] env_s = 8'h00;
    logic       pat = 1'b0;
    bit         pat_mode = 1'b0;
    always @(posedge clk) begin
        if (lfsr_load) begin
            env_s <= lfsr_seed;
            pat   <= 1'b1;
        end else if (lfsr_en) begin
            env_s <= lfsr_step(env_s);
            pat   <= ~pat;
        end
    end
    assign lfsr_bit = pat_mode ? pat : env_s[7];

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: timeline of the current burst in absolute cycle numbers
    bit                chk_en = 1'b0;
    bit                m_active = 1'b0;
    int                m_acc = -100;
    int                m_ws = 0;
    int                m_err_cyc = -100;
    logic [LFSR_W-1:0] m_seed = '0;
    int                last_acc_cyc = -100;
    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] recv[$];
    int                hs_cyc[$];
    int                en_cnt = 0;
    int                load_cnt = 0;
    int                err_cnt = 0;

    always @(negedge clk) begin : cmp
        bit was_active, exp_en, exp_valid, exp_load;
        if (chk_en) begin
            was_active = m_active;
            exp_load   = m_active && (cyc == m_acc);
            exp_en     = m_active && (cyc >= m_ws) && (cyc < m_ws + WORD_W);
            exp_valid  = m_active && (cyc >= m_ws + WORD_W);
            check1("busy", busy, m_active);
            check1("cmd_ready", cmd_ready, !m_active);
            check1("lfsr_load", lfsr_load, exp_load);
            check1("lfsr_en", lfsr_en, exp_en);
            check1("out_valid", out_valid, exp_valid);
            check1("err_zero_seed", err_zero_seed, cyc == m_err_cyc);
            check1("load_en_exclusive", lfsr_load & lfsr_en, 1'b0);
            if (exp_load) check_w("lfsr_seed", 32'(lfsr_seed), 32'(m_seed));
            if (lfsr_en) en_cnt++;
            if (lfsr_load) load_cnt++;
            if (err_zero_seed) err_cnt++;
            if (out_valid && out_ready && !rst) begin
                recv.push_back(out_data);
                hs_cyc.push_back(cyc);
            end
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL model_queue: no expected word at cycle %0d", cyc);
                end else begin
                    check_w("out_data", 32'(out_data), 32'(exp_q[0]));
                    check1("out_last", out_last, exp_q.size() == 1);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) m_active = 1'b0;
                        else m_ws = cyc + 1;
                    end
                end
            end
            if (!was_active && cmd_valid && !rst) begin
                last_acc_cyc = cyc + 1;
                if (cmd_seed == '0) begin
                    m_err_cyc = cyc + 1;
                end else if (cmd_len != '0) begin
                    m_active = 1'b1;
                    m_acc    = cyc + 1;
                    m_ws     = cyc + 2;
                    m_seed   = cmd_seed;
                    for (int k = 0; k < int'(cmd_len); k++) exp_q.push_back(ref_word(cmd_seed, k, pat_mode));
                end
            end
            if (rst) begin
                m_active  = 1'b0;
                m_err_cyc = -100;
                exp_q.delete();
            end
        end
    end

    task automatic send_cmd(input logic [LFSR_W-1:0] seed, input logic [LEN_W-1:0] len);
        bit ok;
        ok = 1'b0;
        cmd_seed  = seed;
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check1("cmd_accept_timeout", ok, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check1("wait_valid_timeout", ok, 1'b1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (!busy && !m_active) begin
                ok = 1'b1;
                break;
            end
        end
        check1("wait_idle_timeout", ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic take_word(input int stall);
        bit ok;
        wait_valid(ok);
        for (int s = 0; s < stall; s++) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, l0, r0, acc;
        bit ok;
        rst = 1'b1; cmd_valid = 1'b0; cmd_seed = '0; cmd_len = '0; out_ready = 1'b0;

        // Hand-computed words pin the reference model
        check_w("ref_lfsr_word0", 32'(ref_word(8'h01, 0, 1'b0)), 32'h01);
        check_w("ref_lfsr_word1", 32'(ref_word(8'h01, 1, 1'b0)), 32'h1C);
        check_w("ref_pattern_word", 32'(ref_word(8'h01, 1, 1'b1)), 32'hAA);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check_w("reset_out_data", 32'(out_data), 32'h0);
        check1("reset_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single burst with 1,0,1,0 bit pattern
        pat_mode = 1'b1; out_ready = 1'b1;
        e0 = en_cnt; l0 = load_cnt;
        send_cmd(8'h01, 16'd1);
        acc = cyc;
        wait_valid(ok);
        if (ok) begin
            check_w("t1_first_valid_latency", 32'(cyc - acc), 32'(WORD_W + 1));
            check_w("t1_data", 32'(out_data), 32'hAA);
            check1("t1_last", out_last, 1'b1);
        end
        wait_idle();
        check_w("t1_en_cycles", 32'(en_cnt - e0), 32'd8);
        check_w("t1_loads", 32'(load_cnt - l0), 32'd1);

        // Backpressure: 5-cycle stall on word 2
        pat_mode = 1'b0; out_ready = 1'b0;
        e0 = en_cnt; r0 = recv.size();
        send_cmd(8'hC3, 16'd3);
        take_word(1);
        take_word(5);
        take_word(1);
        wait_idle();
        check_w("t2_en_cycles", 32'(en_cnt - e0), 32'd24);
        check_w("t2_words", 32'(recv.size() - r0), 32'd3);

        // Zero seed and zero length
        l0 = load_cnt; e0 = err_cnt; r0 = recv.size();
        send_cmd(8'h00, 16'd4);
        repeat (3) @(posedge clk);
        #1;
        check_w("t3_err_pulses", 32'(err_cnt - e0), 32'd1);
        send_cmd(8'h5A, 16'd0);
        repeat (12) @(posedge clk);
        #1;
        check_w("t3_no_load", 32'(load_cnt - l0), 32'd0);
        check_w("t3_no_words", 32'(recv.size() - r0), 32'd0);

        // Command during SHIFT is held off until IDLE
        out_ready = 1'b1;
        send_cmd(8'h5A, 16'd2);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (lfsr_en) begin
                ok = 1'b1;
                break;
            end
        end
        check1("t4_reach_shift", ok, 1'b1);
        check1("t4_ready_low_in_shift", cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        send_cmd(8'h33, 16'd1);
        wait_idle();

        // Reset while a word is pending
        out_ready = 1'b0;
        send_cmd(8'h81, 16'd3);
        wait_valid(ok);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check1("t5_valid_dropped", out_valid, 1'b0);
        check1("t5_en_low", lfsr_en, 1'b0);
        check1("t5_busy_low", busy, 1'b0);
        check1("t5_cmd_ready", cmd_ready, 1'b1);
        check_w("t5_out_data_cleared", 32'(out_data), 32'h0);
        @(posedge clk);
        #1;

        // LFSR bitstream, 4 words, full throughput
        out_ready = 1'b1;
        recv.delete(); hs_cyc.delete();
        send_cmd(8'h01, 16'd4);
        wait_idle();
        check_w("t6_words", 32'(recv.size()), 32'd4);
        if (recv.size() == 4) begin
            check_w("t6_word0", 32'(recv[0]), 32'h01);
            check_w("t6_word1", 32'(recv[1]), 32'h1C);
            check_w("t6_word3", 32'(recv[3]), 32'(ref_word(8'h01, 3, 1'b0)));
            check_w("t6_period", 32'(hs_cyc[3] - hs_cyc[2]), 32'(WORD_W + 1));
        end

        // Randomized commands, backpressure and occasional resets
        for (int t = 0; t < 4000; t++) begin
            @(posedge clk);
            #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                cmd_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (cmd_valid && last_acc_cyc == cyc) cmd_valid = 1'b0;
            else if (!cmd_valid && !rst && $urandom_range(0, 7) == 0) begin
                cmd_valid = 1'b1;
                cmd_seed  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
                cmd_len   = LEN_W'($urandom_range(0, 5));
            end
        end
        cmd_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
